// File: rtl/ysyx_24110006_lsu_pkg.sv
// Shared types and constants for the ysyx_24110006 load/store unit.
package ysyx_24110006_lsu_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW_W = 3'd3,
    ST_B    = 3'd4,
    ST_DONE = 3'd5
  } lsu_state_e;

  // Load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Unshifted store byte masks
  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // AXI response codes
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Natural-alignment check; a load takes priority over a store when both are set.
  function automatic logic is_misaligned(input logic       ren,
                                         input logic       wen,
                                         input logic [2:0] read_t,
                                         input logic [3:0] wmask,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (ren) begin
      case (read_t)
        LW:      mis = (addr_lo != 2'b00);
        LH, LHU: mis = addr_lo[0];
        default: mis = 1'b0;
      endcase
    end else if (wen) begin
      case (wmask)
        MASK_W:  mis = (addr_lo != 2'b00);
        MASK_H:  mis = addr_lo[0];
        default: mis = 1'b0;
      endcase
    end else begin
      mis = 1'b0;
    end
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_24110006_lsu_align.sv
// Byte-lane steering: load extract/extend and store shift onto the 32-bit bus.
module ysyx_24110006_lsu_align
  import ysyx_24110006_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  read_t_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wmask_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_data_o,
  output logic [3:0]  store_strb_o
);

  logic [31:0] rshift_s;

  // Bring the addressed lane down to bit 0, then sign- or zero-extend it.
  always_comb begin
    rshift_s = rdata_i >> {addr_lo_i, 3'b000};
    case (read_t_i)
      LB:      load_data_o = {{24{rshift_s[7]}}, rshift_s[7:0]};
      LH:      load_data_o = {{16{rshift_s[15]}}, rshift_s[15:0]};
      LBU:     load_data_o = {24'd0, rshift_s[7:0]};
      LHU:     load_data_o = {16'd0, rshift_s[15:0]};
      LW:      load_data_o = rshift_s;
      default: load_data_o = rdata_i;
    endcase
  end

  // Move store data and byte strobes up to the addressed lanes.
  always_comb begin
    store_data_o = wdata_i << {addr_lo_i, 3'b000};
    store_strb_o = wmask_i << addr_lo_i;
  end

endmodule

// File: rtl/ysyx_24110006_lsu.sv
// Load/store unit: turns one execute-stage instruction into at most one
// single-beat AXI4-Lite transaction and returns the write-back value.
module ysyx_24110006_lsu
  import ysyx_24110006_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic              i_mem_ren,
  input  logic              i_mem_wen,
  input  logic [3:0]        i_mem_wmask,
  input  logic [2:0]        i_mem_read_t,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_result,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_result,
  output logic              o_fault,
  output logic [ADDR_W-1:0] o_araddr,
  output logic              o_arvalid,
  input  logic              i_arready,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_rresp,
  input  logic              i_rvalid,
  output logic              o_rready,
  output logic [ADDR_W-1:0] o_awaddr,
  output logic              o_awvalid,
  input  logic              i_awready,
  output logic [DATA_W-1:0] o_wdata,
  output logic [3:0]        o_wstrb,
  output logic              o_wvalid,
  input  logic              i_wready,
  input  logic [1:0]        i_bresp,
  input  logic              i_bvalid,
  output logic              o_bready
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        read_t_q, read_t_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              fault_q, fault_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic              misalign_s;
  logic              aw_fin_s;
  logic              w_fin_s;
  logic [31:0]       load_data_s;
  logic [31:0]       store_data_s;
  logic [3:0]        store_strb_s;

  assign misalign_s = is_misaligned(i_mem_ren, i_mem_wen, i_mem_read_t,
                                    i_mem_wmask, i_mem_addr[1:0]);
  // A channel is finished once it handshook earlier or is handshaking now.
  assign aw_fin_s   = aw_done_q | (o_awvalid & i_awready);
  assign w_fin_s    = w_done_q  | (o_wvalid  & i_wready);

  ysyx_24110006_lsu_align u_align (
    .rdata_i      (i_rdata),
    .addr_lo_i    (addr_q[1:0]),
    .read_t_i     (read_t_q),
    .wdata_i      (wdata_q),
    .wmask_i      (wmask_q),
    .load_data_o  (load_data_s),
    .store_data_o (store_data_s),
    .store_strb_o (store_strb_s)
  );

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      read_t_q  <= 3'd0;
      wmask_q   <= 4'd0;
      wdata_q   <= '0;
      res_q     <= '0;
      result_q  <= '0;
      fault_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      read_t_q  <= read_t_d;
      wmask_q   <= wmask_d;
      wdata_q   <= wdata_d;
      res_q     <= res_d;
      result_q  <= result_d;
      fault_q   <= fault_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next-state logic: alignment faults and non-memory ops skip the bus.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          if (misalign_s)     state_d = ST_DONE;
          else if (i_mem_ren) state_d = ST_AR;
          else if (i_mem_wen) state_d = ST_AW_W;
          else                state_d = ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_AR: begin
        if (o_arvalid && i_arready) state_d = ST_R;
        else                        state_d = ST_AR;
      end
      ST_R: begin
        if (i_rvalid) state_d = ST_DONE;
        else          state_d = ST_R;
      end
      ST_AW_W: begin
        if (aw_fin_s && w_fin_s) state_d = ST_B;
        else                     state_d = ST_AW_W;
      end
      ST_B: begin
        if (i_bvalid) state_d = ST_DONE;
        else          state_d = ST_B;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: capture on accept, write back result/fault on completion.
  always_comb begin
    addr_d    = addr_q;
    read_t_d  = read_t_q;
    wmask_d   = wmask_q;
    wdata_d   = wdata_q;
    res_d     = res_q;
    result_d  = result_q;
    fault_d   = fault_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          addr_d    = i_mem_addr;
          read_t_d  = i_mem_read_t;
          wmask_d   = i_mem_wmask;
          wdata_d   = i_wdata;
          res_d     = i_result;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (misalign_s) begin
            result_d = i_mem_addr;
            fault_d  = 1'b1;
          end else if (!i_mem_ren && !i_mem_wen) begin
            result_d = i_result;
            fault_d  = 1'b0;
          end else begin
            // Bus op: previous result stays visible until this one completes.
            result_d = result_q;
            fault_d  = fault_q;
          end
        end else begin
          addr_d = addr_q;
        end
      end
      ST_R: begin
        if (i_rvalid) begin
          result_d = load_data_s;
          fault_d  = (i_rresp != OKAY);
        end else begin
          result_d = result_q;
        end
      end
      ST_AW_W: begin
        aw_done_d = aw_fin_s;
        w_done_d  = w_fin_s;
      end
      ST_B: begin
        if (i_bvalid) begin
          result_d = res_q;
          fault_d  = (i_bresp != OKAY);
        end else begin
          result_d = result_q;
        end
      end
      default: result_d = result_q;
    endcase
  end

  // Output decode from the registered state; AW and W drop independently.
  always_comb begin
    o_valid   = 1'b0;
    o_arvalid = 1'b0;
    o_rready  = 1'b0;
    o_awvalid = 1'b0;
    o_wvalid  = 1'b0;
    o_bready  = 1'b0;
    case (state_q)
      ST_AR:   o_arvalid = 1'b1;
      ST_R:    o_rready  = 1'b1;
      ST_AW_W: begin
        o_awvalid = ~aw_done_q;
        o_wvalid  = ~w_done_q;
      end
      ST_B:    o_bready  = 1'b1;
      ST_DONE: o_valid   = 1'b1;
      default: o_valid   = 1'b0;
    endcase
  end

  assign o_araddr = addr_q;
  assign o_awaddr = {addr_q[ADDR_W-1:2], 2'b00};
  assign o_wdata  = store_data_s;
  assign o_wstrb  = store_strb_s;
  assign o_result = result_q;
  assign o_fault  = fault_q;

endmodule

// File: tb/tb_ysyx_24110006_lsu.sv
// Scoreboard bench for ysyx_24110006_lsu with a delay-configurable AXI4-Lite slave.
module tb_ysyx_24110006_lsu;
  import ysyx_24110006_lsu_pkg::*;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_mem_ren = 1'b0, i_mem_wen = 1'b0;
  logic [3:0]  i_mem_wmask = 4'd0;
  logic [2:0]  i_mem_read_t = 3'd0;
  logic [31:0] i_mem_addr = 32'd0, i_wdata = 32'd0, i_result = 32'd0;
  logic        o_valid, o_fault;
  logic [31:0] o_result, o_araddr, o_awaddr, o_wdata;
  logic [3:0]  o_wstrb;
  logic        o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready;
  logic        i_arready = 1'b0, i_rvalid = 1'b0, i_awready = 1'b0, i_wready = 1'b0, i_bvalid = 1'b0;
  logic [31:0] i_rdata = 32'd0;
  logic [1:0]  i_rresp = 2'b00, i_bresp = 2'b00;

  typedef struct packed { logic [31:0] result; logic fault; } exp_t;
  exp_t  sb_q[$];
  int    checks = 0, errors = 0;
  string cur_name = "none";

  // slave configuration (main thread) and state (slave process)
  int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  bit          r_hang = 1'b0;
  logic [31:0] slv_rdata = 32'd0;
  logic [1:0]  slv_rresp = 2'b00, slv_bresp = 2'b00;
  int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;

  // bus observation (monitor process)
  int          ar_hi = 0, aw_hi = 0, w_hi = 0;
  logic [31:0] last_araddr = 32'd0, last_awaddr = 32'd0, last_wdata = 32'd0;
  logic [3:0]  last_wstrb = 4'd0;
  int          d_ar, d_aw, d_w;

  always #5 i_clock = ~i_clock;

  ysyx_24110006_lsu dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid),
    .i_mem_ren(i_mem_ren), .i_mem_wen(i_mem_wen), .i_mem_wmask(i_mem_wmask),
    .i_mem_read_t(i_mem_read_t), .i_mem_addr(i_mem_addr), .i_wdata(i_wdata),
    .i_result(i_result), .o_valid(o_valid), .o_result(o_result), .o_fault(o_fault),
    .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
    .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Slave: each ready/valid rises after its configured number of wait cycles.
  always @(negedge i_clock) begin
    if (o_arvalid) begin
      i_arready = (ar_cnt >= ar_wait);
      if (ar_cnt < ar_wait) ar_cnt++;
    end else begin
      i_arready = 1'b0; ar_cnt = 0;
    end
    if (o_rready && !r_hang) begin
      i_rvalid = (r_cnt >= r_wait);
      if (r_cnt < r_wait) r_cnt++;
      i_rdata = slv_rdata; i_rresp = slv_rresp;
    end else begin
      i_rvalid = 1'b0; r_cnt = 0;
    end
    if (o_awvalid) begin
      i_awready = (aw_cnt >= aw_wait);
      if (aw_cnt < aw_wait) aw_cnt++;
    end else begin
      i_awready = 1'b0; aw_cnt = 0;
    end
    if (o_wvalid) begin
      i_wready = (w_cnt >= w_wait);
      if (w_cnt < w_wait) w_cnt++;
    end else begin
      i_wready = 1'b0; w_cnt = 0;
    end
    if (o_bready) begin
      i_bvalid = (b_cnt >= b_wait);
      if (b_cnt < b_wait) b_cnt++;
      i_bresp = slv_bresp;
    end else begin
      i_bvalid = 1'b0; b_cnt = 0;
    end
  end

  // Monitor: record bus activity and compare every o_valid against the scoreboard.
  always @(negedge i_clock) begin : monitor
    exp_t e;
    if (o_arvalid) begin ar_hi++; last_araddr = o_araddr; end
    if (o_awvalid) begin aw_hi++; last_awaddr = o_awaddr; end
    if (o_wvalid)  begin w_hi++;  last_wdata = o_wdata; last_wstrb = o_wstrb; end
    if (o_valid) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: o_result 0x%08h with no expected entry", o_result);
      end else begin
        e = sb_q.pop_front();
        check({cur_name, "_result"}, o_result, e.result);
        check({cur_name, "_fault"}, {31'd0, o_fault}, {31'd0, e.fault});
      end
    end
  end

  // Issue one instruction, wait (bounded) for o_valid and check its latency.
  task automatic run_op(input string name, input logic ren, input logic wen,
                        input logic [3:0] mask, input logic [2:0] rt,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] result, input logic [31:0] exp_res,
                        input logic exp_fault, input int exp_lat);
    int a0, aw0, w0, lat;
    cur_name = name;
    sb_q.push_back(exp_t'{result: exp_res, fault: exp_fault});
    a0 = ar_hi; aw0 = aw_hi; w0 = w_hi;
    @(posedge i_clock); #1;
    i_mem_ren = ren; i_mem_wen = wen; i_mem_wmask = mask; i_mem_read_t = rt;
    i_mem_addr = addr; i_wdata = wdata; i_result = result; i_valid = 1'b1;
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge i_clock);
      if (o_valid) begin lat = k; break; end
    end
    check({name, "_latency"}, lat, exp_lat);
    d_ar = ar_hi - a0; d_aw = aw_hi - aw0; d_w = w_hi - w0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k2;
    bit seen;
    repeat (3) @(posedge i_clock);
    #1;
    check("rst_ctrl", {25'd0, o_valid, o_fault, o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready}, 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_addr", o_araddr | o_awaddr, 32'd0);
    check("rst_wdata", o_wdata, 32'd0);
    check("rst_wstrb", {28'd0, o_wstrb}, 32'd0);
    i_reset = 1'b1;

    run_op("pass", 1'b0, 1'b0, 4'd0, 3'd0, 32'h0, 32'h0, 32'h0000_1234, 32'h0000_1234, 1'b0, 1);
    check("pass_bus", d_ar + d_aw + d_w, 32'd0);

    slv_rdata = 32'h80FF_0000;
    run_op("lb", 1'b1, 1'b0, 4'd0, LB, 32'h8000_0003, 32'h0, 32'hCAFE, 32'hFFFF_FF80, 1'b0, 3);
    check("lb_araddr", last_araddr, 32'h8000_0003);
    check("lb_ar_cycles", d_ar, 32'd1);
    run_op("lbu", 1'b1, 1'b0, 4'd0, LBU, 32'h8000_0003, 32'h0, 32'hCAFE, 32'h0000_0080, 1'b0, 3);
    run_op("lh", 1'b1, 1'b0, 4'd0, LH, 32'h8000_0002, 32'h0, 32'h0, 32'hFFFF_80FF, 1'b0, 3);
    run_op("lhu", 1'b1, 1'b0, 4'd0, LHU, 32'h8000_0002, 32'h0, 32'h0, 32'h0000_80FF, 1'b0, 3);
    slv_rdata = 32'h0000_007F;
    run_op("lb_pos", 1'b1, 1'b0, 4'd0, LB, 32'h8000_0000, 32'h0, 32'h0, 32'h0000_007F, 1'b0, 3);

    slv_rdata = 32'hDEAD_BEEF; r_wait = 2;
    run_op("lw_wait", 1'b1, 1'b0, 4'd0, LW, 32'h8000_0004, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 5);
    r_wait = 0;

    aw_wait = 3;
    run_op("sh", 1'b0, 1'b1, MASK_H, 3'd0, 32'h8000_0002, 32'h0000_BEEF, 32'hAAAA_0001,
           32'hAAAA_0001, 1'b0, 6);
    check("sh_awaddr", last_awaddr, 32'h8000_0000);
    check("sh_wdata", last_wdata, 32'hBEEF_0000);
    check("sh_wstrb", {28'd0, last_wstrb}, 32'h0000_000C);
    check("sh_w_cycles", d_w, 32'd1);
    check("sh_aw_cycles", d_aw, 32'd4);
    check("sh_ar_cycles", d_ar, 32'd0);
    aw_wait = 0;

    run_op("sb", 1'b0, 1'b1, MASK_B, 3'd0, 32'h1000_0001, 32'h1234_5678, 32'h0000_0042,
           32'h0000_0042, 1'b0, 3);
    check("sb_awaddr", last_awaddr, 32'h1000_0000);
    check("sb_wdata", last_wdata, 32'h3456_7800);
    check("sb_wstrb", {28'd0, last_wstrb}, 32'h0000_0002);

    run_op("lw_mis", 1'b1, 1'b0, 4'd0, LW, 32'h8000_0001, 32'h0, 32'h5, 32'h8000_0001, 1'b1, 1);
    check("lw_mis_bus", d_ar + d_aw + d_w, 32'd0);
    run_op("sh_mis", 1'b0, 1'b1, MASK_H, 3'd0, 32'h8000_0003, 32'h1, 32'h5, 32'h8000_0003, 1'b1, 1);
    check("sh_mis_bus", d_ar + d_aw + d_w, 32'd0);

    slv_bresp = SLVERR;
    run_op("sw_slverr", 1'b0, 1'b1, MASK_W, 3'd0, 32'h8000_0008, 32'h11, 32'h0000_0055,
           32'h0000_0055, 1'b1, 3);
    slv_bresp = OKAY;
    run_op("pass2", 1'b0, 1'b0, 4'd0, 3'd0, 32'h0, 32'h0, 32'h0000_0077, 32'h0000_0077, 1'b0, 1);

    slv_rresp = DECERR; slv_rdata = 32'h0102_0304;
    run_op("lw_decerr", 1'b1, 1'b0, 4'd0, LW, 32'h8000_000C, 32'h0, 32'h0, 32'h0102_0304, 1'b1, 3);
    slv_rresp = OKAY;

    slv_rdata = 32'h0BAD_F00D;
    run_op("ld_wins", 1'b1, 1'b1, MASK_W, LW, 32'h8000_0010, 32'hFFFF, 32'h9, 32'h0BAD_F00D, 1'b0, 3);
    check("ld_wins_store_bus", d_aw + d_w, 32'd0);
    check("ld_wins_ar_cycles", d_ar, 32'd1);

    // Reset in the middle of a read whose data never arrives.
    r_hang = 1'b1;
    @(posedge i_clock); #1;
    i_mem_ren = 1'b1; i_mem_wen = 1'b0; i_mem_read_t = LW; i_mem_addr = 32'h8000_0020;
    i_valid = 1'b1;
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    seen = 1'b0;
    for (k2 = 0; k2 < 20; k2++) begin
      @(negedge i_clock);
      if (o_rready) begin seen = 1'b1; break; end
    end
    check("hang_reached_r", {31'd0, seen}, 32'd1);
    i_reset = 1'b0;
    @(posedge i_clock); #1;
    check("midrst_ctrl", {25'd0, o_valid, o_fault, o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready}, 32'd0);
    check("midrst_result", o_result, 32'd0);
    i_reset = 1'b1; r_hang = 1'b0;
    slv_rdata = 32'h0000_FF00;
    run_op("after_rst", 1'b1, 1'b0, 4'd0, LB, 32'h8000_0021, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 3);

    repeat (3) @(negedge i_clock);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24110006_lsu.md
# ysyx_24110006_lsu

Load/store unit sitting directly downstream of the execute stage. Accepts one instruction per `i_valid` pulse, carrying the memory controls and ALU result the execute stage produces. Memory ops become single-beat AXI4-Lite transactions; load data is lane-extracted and extended; the write-back value is returned with a one-cycle `o_valid` pulse. Non-memory instructions pass through in one cycle.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; only 32 supported

Ports:
- i_clock  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-low reset (0 = reset)
- i_valid  in  1  one-cycle pulse: upstream instruction valid
- i_mem_ren  in  1  load
- i_mem_wen  in  1  store
- i_mem_wmask  in  4  unshifted byte mask (0001 sb, 0011 sh, 1111 sw)
- i_mem_read_t  in  3  load funct3 (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu)
- i_mem_addr  in  32  effective address
- i_wdata  in  32  store data (rs2), unshifted
- i_result  in  32  ALU result, forwarded for non-loads
- o_valid  out  1  one-cycle pulse: o_result/o_fault valid
- o_result  out  32  write-back value
- o_fault  out  1  access fault (misaligned or bus error)
- o_araddr/o_arvalid, i_arready; i_rdata[32]/i_rresp[2]/i_rvalid, o_rready  AXI4-Lite read
- o_awaddr/o_awvalid, i_awready; o_wdata[32]/o_wstrb[4]/o_wvalid, i_wready; i_bresp[2]/i_bvalid, o_bready  AXI4-Lite write

## Operation
- States: IDLE, AR, R, AW_W, B, DONE.
- IDLE, i_valid=1: register all inputs. Misaligned (lw/sw with addr[1:0]≠0; lh/lhu/sh with addr[0]=1) → DONE with fault, no bus traffic, o_result = i_mem_addr. Else ren → AR; wen → AW_W; neither → DONE, o_result = i_result, fault 0.
- ren and wen both 1: load wins, store dropped. i_valid outside IDLE is ignored.
- AR: o_arvalid=1, o_araddr = addr. arvalid&&arready → R.
- R: o_rready=1. On rvalid: extract byte/half at addr[1:0], sign- or zero-extend per read_t, store in o_result; o_fault = (rresp≠00) → DONE.
- AW_W: o_awvalid and o_wvalid asserted independently; each drops after its own handshake (aw_done/w_done flags). Both done → B. o_awaddr = {addr[31:2],2'b00}; o_wdata = wdata << 8·addr[1:0]; o_wstrb = wmask << addr[1:0].
- B: o_bready=1. On bvalid: o_fault = (bresp≠00), o_result = i_result → DONE.
- DONE: o_valid=1 for exactly one cycle → IDLE.

## Timing
- Reset (i_reset=0 at an edge): state IDLE; o_valid, o_fault, all *valid, o_rready, o_bready = 0; o_result, addresses, o_wdata, o_wstrb = 0.
- Reset mid-transaction: bus valids drop the next edge; the transaction is abandoned (slave is reset together).
- Non-memory: accept edge N, o_valid in cycle N+1.
- Load, zero-wait slave: accept N, arvalid cycle N+1, rready N+2, o_valid N+3. Each slave wait cycle adds one.
- Store, zero-wait: accept N, aw/w valid N+1, bready N+2, o_valid N+3.
- Valid signals never drop before handshake; address/data stable while valid.
- o_result/o_fault hold their values until the next DONE.

## Structure
- Package ysyx_24110006_lsu_pkg: state enum; read_t constants (LB, LH, LW, LBU, LHU); resp constants OKAY=00, SLVERR=10, DECERR=11.
- Sub-module ysyx_24110006_lsu_align (combinational): load extract/extend from rdata + addr[1:0] + read_t; store lane shift of wdata/wmask.
- Top holds the FSM, input registers, and handshake flags.

## Test plan
- Pass-through: i_valid, ren=wen=0, i_result=0x1234 → o_valid next cycle, o_result=0x1234, no AXI valids.
- lb addr 0x80000003, rdata 0x80FF_0000 → araddr 0x80000003, o_result 0xFFFFFF80; same with lbu → 0x00000080.
- sh addr 0x80000002, wdata 0x0000BEEF, mask 0011 → awaddr 0x80000000, wdata 0xBEEF0000, wstrb 1100; awready delayed 3 cycles, wready immediate → wvalid drops after 1 cycle, awvalid held until handshake, single o_valid.
- lw addr 0x80000001 → no arvalid, o_valid next cycle, o_fault=1, o_result=0x80000001.
- bresp=10 on sw → o_fault=1; next non-mem op → o_fault=0.
- Reset asserted during R with rvalid never arriving → all valids 0 next edge; new load after release completes normally.
